// File: rtl/jpeg_dec_pkg.sv
// Shared types and sizes for the JPEG decode pipe row/column stages.
package jpeg_dec_pkg;

  localparam int unsigned TOK_W = 16;
  localparam int unsigned ROW_N = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_EOS  = 2'd2
  } state_t;

endpackage

// File: rtl/rowsplit_buf.sv
// Row register file: one lane written per token, tail lanes cleared on a short row.
module rowsplit_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 8,
  parameter int unsigned IDX_W = $clog2(LANES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     clr,
  input  logic [IDX_W-1:0]         cidx,
  output logic [LANES*WIDTH-1:0]   rd
);

  logic [LANES-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (we && (widx == IDX_W'(k))) begin
          mem[k] <= wdata;
        end else if (clr && (IDX_W'(k) >= cidx)) begin
          mem[k] <= '0;
        end
      end
    end
  end

  assign rd = mem;

endmodule

// File: rtl/rowsplit_d1.sv
// Serial-to-row writer: gathers LANES tokens and emits them on LANES parallel lanes,
// padding a short final row and following it with an all-lane EOS token.
module rowsplit_d1
  import jpeg_dec_pkg::*;
#(
  parameter int unsigned WIDTH = TOK_W,
  parameter int unsigned LANES = ROW_N
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         i_d,
  input  logic                     i_e,
  input  logic                     i_v,
  output logic                     i_b,
  output logic [LANES*WIDTH-1:0]   o_d,
  output logic [LANES-1:0]         o_e,
  output logic [LANES-1:0]         o_v,
  input  logic [LANES-1:0]         o_b
);

  localparam int unsigned CNT_W = $clog2(LANES);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     pend_eos;
  logic [LANES*WIDTH-1:0]   rd;
  logic [LANES*WIDTH-1:0]   row_c;
  logic                     in_fire_c;
  logic                     out_fire_c;
  logic                     buf_we_c;
  logic                     buf_clr_c;

  assign in_fire_c  = (state == ST_FILL) && i_v && !i_b;
  assign out_fire_c = o_v[0] && (o_b == '0);
  assign buf_we_c   = in_fire_c && !i_e;
  assign buf_clr_c  = in_fire_c && i_e && (cnt != '0);

  rowsplit_buf #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .IDX_W (CNT_W)
  ) u_buf (
    .clock (clock),
    .reset (reset),
    .we    (buf_we_c),
    .widx  (cnt),
    .wdata (i_d),
    .clr   (buf_clr_c),
    .cidx  (cnt),
    .rd    (rd)
  );

  // Row as it will look after this edge's write/pad, so o_d can load in the same edge.
  always_comb begin
    row_c = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < cnt) begin
        row_c[k*WIDTH +: WIDTH] = rd[k*WIDTH +: WIDTH];
      end else if ((CNT_W'(k) == cnt) && !i_e) begin
        row_c[k*WIDTH +: WIDTH] = i_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_FILL;
      cnt      <= '0;
      pend_eos <= 1'b0;
      i_b      <= 1'b0;
      o_v      <= '0;
      o_e      <= '0;
      o_d      <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (in_fire_c) begin
            if (!i_e) begin
              if (cnt == CNT_W'(LANES - 1)) begin
                cnt   <= '0;
                state <= ST_EMIT;
                i_b   <= 1'b1;
                o_v   <= '1;
                o_e   <= '0;
                o_d   <= row_c;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (cnt == '0) begin
              state <= ST_EOS;
              i_b   <= 1'b1;
              o_v   <= '1;
              o_e   <= '1;
              o_d   <= '0;
            end else begin
              cnt      <= '0;
              pend_eos <= 1'b1;
              state    <= ST_EMIT;
              i_b      <= 1'b1;
              o_v      <= '1;
              o_e      <= '0;
              o_d      <= row_c;
            end
          end
        end
        ST_EMIT: begin
          if (out_fire_c) begin
            pend_eos <= 1'b0;
            o_d      <= '0;
            if (pend_eos) begin
              state <= ST_EOS;
              o_e   <= '1;
            end else begin
              state <= ST_FILL;
              i_b   <= 1'b0;
              o_v   <= '0;
            end
          end
        end
        ST_EOS: begin
          if (out_fire_c) begin
            state <= ST_FILL;
            cnt   <= '0;
            i_b   <= 1'b0;
            o_v   <= '0;
            o_e   <= '0;
          end
        end
        default: begin
          state <= ST_FILL;
          cnt   <= '0;
          i_b   <= 1'b0;
          o_v   <= '0;
          o_e   <= '0;
          o_d   <= '0;
        end
      endcase
    end
  end

endmodule
